// File: rtl/kpn_fifo_channel.sv
// Bounded FIFO channel between two KPN processes; first-word fall-through head, 0-cycle read latency.
// No internal backpressure: writers stall on full, readers on empty; refused ops raise sticky flags.
module kpn_fifo_channel #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CNT_W-1:0]      cnt;
  logic                  wr_acc;
  logic                  rd_acc;

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

  // A read frees a slot in the same cycle, so a full channel still takes a write alongside a read.
  assign wr_acc = wr && (!full || rd) && !flush;
  assign rd_acc = rd && !empty && !flush;

  assign data_out = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      if (wr && full && !rd) begin
        overflow <= 1'b1;
      end
      if (rd && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kpn_fifo_channel.sv
// Directed bench for kpn_fifo_channel with hand-computed expectations.
module tb_kpn_fifo_channel;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        wr;
  logic [15:0] data_in;
  logic        rd;
  logic [15:0] data_out;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;

  int n_cmp  = 0;
  int n_fail = 0;

  kpn_fifo_channel #(.DATA_WIDTH(16), .DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .wr        (wr),
    .data_in   (data_in),
    .rd        (rd),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one clock, then sample 1ns after the edge.
  task automatic cycle(input logic w, input logic [15:0] d, input logic r, input logic f);
    wr = w; data_in = d; rd = r; flush = f;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; flush = 1'b0;
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"},  32'(full), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_dout"},  32'(data_out), 32'h0000);
    check({tag, "_ovf"},   32'(overflow), 32'd0);
    check({tag, "_unf"},   32'(underflow), 32'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; wr = 1'b0; rd = 1'b0; data_in = 16'h0;
    #12 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_idle_state("reset_idle");

    // Three writes then three pops
    cycle(1'b1, 16'h0003, 1'b0, 1'b0);
    check("w1_count", 32'(count), 32'd1);
    check("w1_dout", 32'(data_out), 32'h0003);
    cycle(1'b1, 16'h0005, 1'b0, 1'b0);
    check("w2_count", 32'(count), 32'd2);
    check("w2_dout", 32'(data_out), 32'h0003);
    cycle(1'b1, 16'h0007, 1'b0, 1'b0);
    check("w3_count", 32'(count), 32'd3);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    check("r1_dout", 32'(data_out), 32'h0005);
    check("r1_count", 32'(count), 32'd2);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    check("r2_dout", 32'(data_out), 32'h0007);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    check("r3_dout", 32'(data_out), 32'h0000);
    check("r3_empty", 32'(empty), 32'd1);
    check("r3_unf", 32'(underflow), 32'd0);

    // Fill to full, then one refused write
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'h0010 + 16'(i), 1'b0, 1'b0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd8);
    check("fill_head", 32'(data_out), 32'h0010);
    check("fill_ovf0", 32'(overflow), 32'd0);
    cycle(1'b1, 16'hFFFF, 1'b0, 1'b0);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd8);
    check("ovf_head", 32'(data_out), 32'h0010);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 16'h0000, 1'b1, 1'b0);
      check("drain_count", 32'(count), 32'(7 - k));
      check("drain_dout", 32'(data_out), (k < 7) ? 32'h0011 + 32'(k) : 32'h0);
    end
    check("drain_ovf_sticky", 32'(overflow), 32'd1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    check("flush_ovf", 32'(overflow), 32'd0);
    check("flush_count0", 32'(count), 32'd0);

    // Full channel with simultaneous write and read
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'h0020 + 16'(i), 1'b0, 1'b0);
    check("refill_full", 32'(full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 16'hAAAA, 1'b1, 1'b0);
      check("rw_full_count", 32'(count), 32'd8);
      check("rw_full_ovf", 32'(overflow), 32'd0);
      check("rw_full_head", 32'(data_out), (i < 7) ? 32'h0021 + 32'(i) : 32'hAAAA);
    end
    check("rw_full_flag", 32'(full), 32'd1);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    check("rw_after_pop", 32'(data_out), 32'hAAAA);
    check("rw_after_count", 32'(count), 32'd7);

    // Empty channel with simultaneous write and read, then flush with a dropped write
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    check("flush2_empty", 32'(empty), 32'd1);
    cycle(1'b1, 16'h1234, 1'b1, 1'b0);
    check("rw_empty_count", 32'(count), 32'd1);
    check("rw_empty_dout", 32'(data_out), 32'h1234);
    check("rw_empty_unf", 32'(underflow), 32'd1);
    cycle(1'b1, 16'h5555, 1'b0, 1'b1);
    check("flush3_count", 32'(count), 32'd0);
    check("flush3_unf", 32'(underflow), 32'd0);
    check("flush3_dout", 32'(data_out), 32'h0000);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    check("post_flush_unf", 32'(underflow), 32'd1);

    // Asynchronous reset between edges with tokens loaded
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0050 + 16'(i), 1'b0, 1'b0);
    check("load5_count", 32'(count), 32'd5);
    #2 reset = 1'b1;
    #1;
    check("areset_count", 32'(count), 32'd0);
    check("areset_empty", 32'(empty), 32'd1);
    check("areset_dout", 32'(data_out), 32'h0000);
    check("areset_unf", 32'(underflow), 32'd0);
    check("areset_full", 32'(full), 32'd0);
    #2 reset = 1'b0;
    cycle(1'b1, 16'h0042, 1'b0, 1'b0);
    check("post_reset_count", 32'(count), 32'd1);
    check("post_reset_dout", 32'(data_out), 32'h0042);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
